// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the 256 x 32-bit instruction
// store. Assembles big-endian words, writes consecutive addresses from a base,
// and holds the CPU in reset for the duration of the load.
module imem_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              IMEM_LOADER_clk,
  input  logic              IMEM_LOADER_rst_n,
  input  logic              IMEM_LOADER_start,
  input  logic [ADDR_W-1:0] IMEM_LOADER_base_addr,
  input  logic [ADDR_W:0]   IMEM_LOADER_word_count,
  input  logic              IMEM_LOADER_abort,
  input  logic              IMEM_LOADER_byte_valid,
  input  logic [7:0]        IMEM_LOADER_byte_data,
  output logic              IMEM_LOADER_byte_ready,
  output logic              IMEM_LOADER_wr_en,
  output logic [ADDR_W-1:0] IMEM_LOADER_wr_addr,
  output logic [DATA_W-1:0] IMEM_LOADER_wr_data,
  output logic              IMEM_LOADER_busy,
  output logic              IMEM_LOADER_cpu_hold,
  output logic              IMEM_LOADER_done,
  output logic [DATA_W-1:0] IMEM_LOADER_checksum,
  output logic [ADDR_W:0]   IMEM_LOADER_words_written
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     count_q;
  logic [1:0]          byte_cnt_q;
  logic [DATA_W-1:0]   word_q;
  logic [DATA_W-1:0]   checksum_q;
  logic [ADDR_W:0]     words_q;
  logic [ADDR_W-1:0]   last_addr_q;
  logic [DATA_W-1:0]   last_data_q;
  logic                accept;
  logic [ADDR_W:0]     words_inc;

  assign words_inc = words_q + 1'b1;

  // Next-state decode and per-state output strobes.
  always_comb begin
    state_d                = state_q;
    IMEM_LOADER_byte_ready = 1'b0;
    IMEM_LOADER_busy       = 1'b0;
    IMEM_LOADER_done       = 1'b0;
    IMEM_LOADER_wr_en      = 1'b0;
    accept                 = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (IMEM_LOADER_start) begin
          state_d = (IMEM_LOADER_word_count != '0) ? S_RECV : S_DONE;
        end
      end
      S_RECV: begin
        IMEM_LOADER_busy       = 1'b1;
        IMEM_LOADER_byte_ready = 1'b1;
        if (IMEM_LOADER_abort) begin
          state_d = S_IDLE;
        end else begin
          accept = IMEM_LOADER_byte_valid;
          if (IMEM_LOADER_byte_valid && (byte_cnt_q == 2'd3)) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        IMEM_LOADER_busy = 1'b1;
        if (IMEM_LOADER_abort) begin
          state_d = S_IDLE;
        end else begin
          IMEM_LOADER_wr_en = 1'b1;
          state_d = (words_inc == count_q) ? S_DONE : S_RECV;
        end
      end
      S_DONE: begin
        IMEM_LOADER_done = 1'b1;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register plus load datapath: parameters, word assembly, write bookkeeping.
  always_ff @(posedge IMEM_LOADER_clk) begin
    if (!IMEM_LOADER_rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      checksum_q  <= '0;
      words_q     <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (IMEM_LOADER_start && (IMEM_LOADER_word_count != '0)) begin
            addr_q     <= IMEM_LOADER_base_addr;
            count_q    <= IMEM_LOADER_word_count;
            checksum_q <= '0;
            words_q    <= '0;
            byte_cnt_q <= '0;
          end
        end
        S_RECV: begin
          if (IMEM_LOADER_abort) begin
            byte_cnt_q <= '0;
          end else if (accept) begin
            word_q     <= {word_q[DATA_W-9:0], IMEM_LOADER_byte_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        end
        S_WRITE: begin
          byte_cnt_q <= '0;
          if (!IMEM_LOADER_abort) begin
            checksum_q  <= checksum_q ^ word_q;
            words_q     <= words_inc;
            addr_q      <= addr_q + 1'b1;
            last_addr_q <= addr_q;
            last_data_q <= word_q;
          end
        end
        default: ;
      endcase
    end
  end

  // addr_q advances and word_q refills after the write, so the write port
  // shows the live values only while strobing and the captured copy otherwise.
  always_comb begin
    IMEM_LOADER_wr_addr       = IMEM_LOADER_wr_en ? addr_q : last_addr_q;
    IMEM_LOADER_wr_data       = IMEM_LOADER_wr_en ? word_q : last_data_q;
    IMEM_LOADER_cpu_hold      = IMEM_LOADER_busy;
    IMEM_LOADER_checksum      = checksum_q;
    IMEM_LOADER_words_written = words_q;
  end

endmodule
